// File: rtl/ifu_prefetch_queue_if.sv
// Bundles the fetch control, the IDU handshake and the AXI4 read channels of
// the instruction prefetch queue. The master modport is the fetch unit's view.
interface ifu_prefetch_queue_if;
  // Fetch control
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  // IDU handshake
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;
  // AXI4 read address channel
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  // AXI4 read data channel
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc, out_ready,
           arready, rvalid, rdata, rresp, rlast,
    output out_valid, out_inst, out_pc, out_fault,
           arvalid, araddr, arlen, arsize, arburst, rready
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc, out_ready,
           arready, rvalid, rdata, rresp, rlast,
    input  out_valid, out_inst, out_pc, out_fault,
           arvalid, araddr, arlen, arsize, arburst, rready
  );
endinterface

// File: rtl/ifu_prefetch_queue.sv
// Instruction prefetch queue: fetches aligned blocks of sequential words over
// AXI4 (one INCR burst or BURST_LEN single-beat reads per block) into a small
// FIFO and presents {inst, pc, fault} to the decoder with valid/ready.
module ifu_prefetch_queue #(
  parameter logic [31:0] RESET_PC  = 32'h3000_0000,
  parameter int          DEPTH     = 4,
  parameter int          BURST_LEN = 4,
  parameter bit          BURST_EN  = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  ifu_prefetch_queue_if.master bus
);

  localparam int BLK_BYTES = 4 * BURST_LEN;
  localparam int BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W     = $clog2(DEPTH + 1);

  localparam logic [31:0]       BLK_MASK  = ~(32'(BLK_BYTES) - 32'd1);
  localparam logic [CNT_W-1:0]  ISSUE_MAX = CNT_W'(DEPTH - BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [31:0]       fetch_pc_q;
  logic [31:0]       base_q;
  logic [BEAT_W-1:0] off_q;
  logic [BEAT_W-1:0] beat_q;
  logic              halted_q;
  logic              redir_seen_q;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic [31:0] inst_mem  [DEPTH];
  logic [31:0] pc_mem    [DEPTH];
  logic        fault_mem [DEPTH];

  logic              issue, push, pop, beat_adv, arvalid;
  logic [31:0]       fetch_base, beat_addr;
  logic [BEAT_W-1:0] fetch_off;
  logic              xfer_done, block_end;
  logic              unused_pc_lo;

  assign fetch_base = fetch_pc_q & BLK_MASK;
  assign fetch_off  = (BURST_LEN == 1) ? '0 : fetch_pc_q[BEAT_W+1:2];
  assign beat_addr  = base_q + {{(30-BEAT_W){1'b0}}, beat_q, 2'b00};
  // xfer_done: the outstanding AR is fully answered; block_end: the whole block is.
  assign xfer_done  = bus.rvalid & (BURST_EN ? bus.rlast : 1'b1);
  assign block_end  = bus.rvalid & (BURST_EN ? bus.rlast : (beat_q == LAST_BEAT));
  assign pop        = bus.out_valid & bus.out_ready;
  assign unused_pc_lo = ^bus.redirect_pc[1:0];

  // Fetch sequencing: next state, AR request and FIFO push decision.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    issue    = 1'b0;
    push     = 1'b0;
    beat_adv = 1'b0;
    arvalid  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.fetch_en && !halted_q && !bus.redirect_valid && (count_q <= ISSUE_MAX)) begin
          issue   = 1'b1;
          state_d = S_AR;
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (bus.arready)
          state_d = (redir_seen_q || bus.redirect_valid) ? S_DRAIN : S_R;
      end
      S_R: begin
        if (bus.redirect_valid) begin
          // The beat of this cycle is dropped; drain only if more beats are owed.
          state_d = xfer_done ? S_IDLE : S_DRAIN;
        end else if (bus.rvalid) begin
          push     = (beat_q >= off_q);
          beat_adv = 1'b1;
          if (block_end)     state_d = S_IDLE;
          else if (!BURST_EN) state_d = S_AR;
        end
      end
      S_DRAIN: begin
        if (xfer_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Fetch address, block bookkeeping, halt flag and FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      base_q       <= '0;
      off_q        <= '0;
      beat_q       <= '0;
      halted_q     <= 1'b0;
      redir_seen_q <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      if (bus.redirect_valid)  fetch_pc_q <= {bus.redirect_pc[31:2], 2'b00};
      else if (issue)          fetch_pc_q <= fetch_base + 32'(BLK_BYTES);

      if (issue) begin
        base_q <= fetch_base;
        off_q  <= fetch_off;
        beat_q <= '0;
      end else if (beat_adv) begin
        beat_q <= beat_q + 1'b1;
      end

      if (bus.redirect_valid)              halted_q <= 1'b0;
      else if (push && bus.rresp != 2'b00) halted_q <= 1'b1;

      // Remember a redirect seen while the AR is still waiting for arready.
      redir_seen_q <= (state_q == S_AR) && (state_d == S_AR) &&
                      (redir_seen_q || bus.redirect_valid);

      if (bus.redirect_valid) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
    if (push) begin
      inst_mem[wr_ptr_q]  <= bus.rdata;
      pc_mem[wr_ptr_q]    <= beat_addr;
      fault_mem[wr_ptr_q] <= (bus.rresp != 2'b00);
    end
  end

  assign bus.out_valid = (count_q != '0);
  assign bus.out_inst  = inst_mem[rd_ptr_q];
  assign bus.out_pc    = pc_mem[rd_ptr_q];
  assign bus.out_fault = fault_mem[rd_ptr_q];

  assign bus.arvalid = arvalid;
  assign bus.araddr  = BURST_EN ? base_q : beat_addr;
  assign bus.arlen   = BURST_EN ? 8'(BURST_LEN - 1) : 8'd0;
  assign bus.arsize  = 3'b010;
  assign bus.arburst = BURST_EN ? 2'b01 : 2'b00;
  assign bus.rready  = 1'b1;

endmodule
